// File: rtl/aidc_lite_bpc_pkg.sv
// Shared geometry, code-prefix constants and enums for the AIDC-Lite BPC decompressor.
package aidc_lite_bpc_pkg;

    localparam int unsigned NUM_WORDS  = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned NUM_PLANES = 33;
    localparam int unsigned PLANE_W    = 31;
    localparam int unsigned MAX_BEATS  = 16;
    localparam int unsigned BEAT_W     = 64;
    localparam int unsigned WIN_W      = 36;
    localparam int unsigned BUF_BITS   = MAX_BEATS * BEAT_W;

    localparam logic       PFX_RAW   = 1'b1;
    localparam logic [1:0] PFX_ZERO1 = 2'b01;
    localparam logic [2:0] PFX_RUN   = 3'b001;
    localparam logic [4:0] PFX_ONES  = 5'b00000;
    localparam logic [4:0] PFX_DBP0  = 5'b00001;
    localparam logic [4:0] PFX_TWO   = 5'b00010;
    localparam logic [4:0] PFX_ONE   = 5'b00011;

    localparam logic [5:0] LEN_RAW   = 6'd32;
    localparam logic [5:0] LEN_ZERO1 = 6'd2;
    localparam logic [5:0] LEN_RUN   = 6'd8;
    localparam logic [5:0] LEN_SHORT = 6'd5;
    localparam logic [5:0] LEN_POS   = 6'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DECODE,
        ST_EMIT
    } state_t;

    typedef enum logic [2:0] {
        CODE_RAW,
        CODE_ZERO1,
        CODE_RUN,
        CODE_ONES,
        CODE_DBP0,
        CODE_TWO,
        CODE_ONE
    } code_t;

endpackage

// File: rtl/aidc_lite_bpc_code_dec.sv
// Combinational decoder for one DBX plane code taken from a 36-bit MSB-first window.
module aidc_lite_bpc_code_dec
    import aidc_lite_bpc_pkg::*;
(
    input  logic [WIN_W-1:0]   window,
    output code_t              code_type,
    output logic [5:0]         code_len,
    output logic [5:0]         run_len,
    output logic [PLANE_W-1:0] dbx,
    output logic               range_err
);

    logic [4:0] pos_field;
    logic [4:0] run_field;
    logic       unused_tail;

    assign pos_field   = window[WIN_W-6 -: 5];
    assign run_field   = window[WIN_W-4 -: 5];
    // The longest code is 32 bits; the last window bits never carry payload.
    assign unused_tail = ^window[3:0];

    always_comb begin
        code_type = CODE_RAW;
        code_len  = LEN_RAW;
        run_len   = 6'd1;
        dbx       = '0;
        range_err = 1'b0;
        if (window[WIN_W-1] == PFX_RAW) begin
            dbx = window[WIN_W-2 -: PLANE_W];
        end else if (window[WIN_W-1 -: 2] == PFX_ZERO1) begin
            code_type = CODE_ZERO1;
            code_len  = LEN_ZERO1;
        end else if (window[WIN_W-1 -: 3] == PFX_RUN) begin
            code_type = CODE_RUN;
            code_len  = LEN_RUN;
            run_len   = {1'b0, run_field} + 6'd2;
        end else begin
            case (window[WIN_W-1 -: 5])
                PFX_ONES: begin
                    code_type = CODE_ONES;
                    code_len  = LEN_SHORT;
                    dbx       = '1;
                end
                PFX_DBP0: begin
                    code_type = CODE_DBP0;
                    code_len  = LEN_SHORT;
                end
                PFX_TWO: begin
                    code_type = CODE_TWO;
                    code_len  = LEN_POS;
                    dbx       = PLANE_W'(3) << pos_field;
                    range_err = pos_field > 5'd29;
                end
                default: begin
                    code_type = CODE_ONE;
                    code_len  = LEN_POS;
                    dbx       = PLANE_W'(1) << pos_field;
                    range_err = pos_field > 5'd30;
                end
            endcase
        end
    end

endmodule

// File: rtl/aidc_lite_decomp_bpc.sv
// AIDC-Lite BPC decompressor: collects up to 16 compressed beats, rebuilds the delta
// bit-planes one per cycle, then emits the 1024-bit block as 16 prefix-summed beats.
module aidc_lite_decomp_bpc
    import aidc_lite_bpc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic        sop_i,
    input  logic        eop_i,
    input  logic        raw_i,
    input  logic [63:0] data_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic        sop_o,
    output logic        eop_o,
    output logic [63:0] data_o,
    output logic        done_o,
    output logic        error_o
);

    state_t             state;
    logic               raw_q;
    logic [4:0]         beat_cnt;
    // One bit wider than a buffer index so a stream ending exactly at bit 1024 still overruns cleanly.
    logic [10:0]        bit_ptr;
    logic [5:0]         plane_cnt;
    logic [5:0]         run_cnt;
    logic [3:0]         emit_idx;
    logic [WORD_W-1:0]  acc;
    logic [PLANE_W-1:0] dbp_prev;

    logic [BEAT_W-1:0]  buf_q [MAX_BEATS];
    logic [PLANE_W-1:0] dbp_q [NUM_PLANES];

    logic               buf_we;
    logic [3:0]         buf_idx;

    always_comb begin
        buf_we  = 1'b0;
        buf_idx = beat_cnt[3:0];
        if (valid_i) begin
            if (state == ST_IDLE && sop_i) begin
                buf_we  = 1'b1;
                buf_idx = '0;
            end else if (state == ST_COLLECT && beat_cnt != 5'(MAX_BEATS)) begin
                buf_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_q[buf_idx] <= data_i;
    end

    logic [BUF_BITS+WIN_W-1:0] stream;
    logic [WIN_W-1:0]          window;

    always_comb begin
        stream = '0;
        for (int unsigned b = 0; b < MAX_BEATS; b++) begin
            stream[BUF_BITS+WIN_W-1-BEAT_W*b -: BEAT_W] = buf_q[b];
        end
        window = WIN_W'(stream >> (11'(BUF_BITS) - bit_ptr));
    end

    code_t              code_type;
    logic [5:0]         code_len;
    logic [5:0]         run_len;
    logic [PLANE_W-1:0] dbx;
    logic               range_err;

    aidc_lite_bpc_code_dec u_code_dec (
        .window    (window),
        .code_type (code_type),
        .code_len  (code_len),
        .run_len   (run_len),
        .dbx       (dbx),
        .range_err (range_err)
    );

    logic [10:0]        avail;
    logic [11:0]        need;
    logic               run_active;
    logic               plane_step;
    logic               code_err;
    logic [PLANE_W-1:0] dbp_new;

    always_comb begin
        avail      = {beat_cnt, 6'd0};
        need       = {1'b0, bit_ptr} + {6'd0, code_len};
        run_active = run_cnt != '0;
        plane_step = state == ST_DECODE && plane_cnt != 6'(NUM_PLANES);
        code_err   = !run_active &&
                     (need > {1'b0, avail} || range_err || run_len > plane_cnt + 6'd1);
        if (run_active)                  dbp_new = dbp_prev;
        else if (code_type == CODE_DBP0) dbp_new = '0;
        else                             dbp_new = dbx ^ dbp_prev;
    end

    always_ff @(posedge clk) begin
        if (plane_step && !code_err) dbp_q[plane_cnt] <= dbp_new;
    end

    // Column j of the plane store is delta d[j+1]; each beat needs d[2b+1] and d[2b+2].
    logic [4:0]        col_hi;
    logic [4:0]        col_nx;
    logic [WORD_W-1:0] d_hi;
    logic [WORD_W-1:0] d_nx;
    logic [WORD_W-1:0] w_hi;

    always_comb begin
        col_hi = {emit_idx, 1'b0};
        col_nx = (emit_idx == 4'd15) ? 5'd0 : col_hi + 5'd1;
        d_hi   = '0;
        d_nx   = '0;
        for (int unsigned k = 0; k < WORD_W; k++) begin
            d_hi[k] = dbp_q[k][col_hi];
            d_nx[k] = dbp_q[k][col_nx];
        end
        w_hi = acc + d_hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            raw_q     <= 1'b0;
            beat_cnt  <= '0;
            bit_ptr   <= '0;
            plane_cnt <= '0;
            run_cnt   <= '0;
            emit_idx  <= '0;
            acc       <= '0;
            dbp_prev  <= '0;
            busy_o    <= 1'b0;
            valid_o   <= 1'b0;
            sop_o     <= 1'b0;
            eop_o     <= 1'b0;
            data_o    <= '0;
            done_o    <= 1'b0;
            error_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            sop_o   <= 1'b0;
            eop_o   <= 1'b0;
            data_o  <= '0;
            done_o  <= 1'b0;
            error_o <= 1'b0;
            busy_o  <= state != ST_IDLE;
            case (state)
                ST_IDLE: begin
                    if (valid_i && sop_i) begin
                        raw_q     <= raw_i;
                        beat_cnt  <= 5'd1;
                        busy_o    <= 1'b1;
                        plane_cnt <= 6'(NUM_PLANES);
                        emit_idx  <= '0;
                        if (eop_i) state <= raw_i ? ST_EMIT : ST_DECODE;
                        else       state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (valid_i) begin
                        if (beat_cnt == 5'(MAX_BEATS)) begin
                            error_o <= 1'b1;
                            done_o  <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 5'd1;
                            if (eop_i) state <= raw_q ? ST_EMIT : ST_DECODE;
                        end
                    end
                end
                ST_DECODE: begin
                    if (!plane_step) begin
                        acc       <= buf_q[0][BEAT_W-1 -: WORD_W];
                        bit_ptr   <= 11'(WORD_W);
                        dbp_prev  <= '0;
                        run_cnt   <= '0;
                        plane_cnt <= plane_cnt - 6'd1;
                    end else if (code_err) begin
                        error_o <= 1'b1;
                        done_o  <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        dbp_prev <= dbp_new;
                        if (run_active) begin
                            run_cnt <= run_cnt - 6'd1;
                        end else begin
                            bit_ptr <= bit_ptr + 11'(code_len);
                            run_cnt <= run_len - 6'd1;
                        end
                        if (plane_cnt == '0) begin
                            state    <= ST_EMIT;
                            emit_idx <= '0;
                        end else begin
                            plane_cnt <= plane_cnt - 6'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    valid_o  <= 1'b1;
                    sop_o    <= emit_idx == '0;
                    eop_o    <= emit_idx == 4'd15;
                    data_o   <= raw_q ? buf_q[emit_idx] : {w_hi, acc};
                    acc      <= w_hi + d_nx;
                    emit_idx <= emit_idx + 4'd1;
                    if (emit_idx == 4'd15) begin
                        done_o <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aidc_lite_decomp_bpc.sv
// Bench for aidc_lite_decomp_bpc: a behavioural BPC encoder builds streams from known
// blocks and the decompressed beats and handshake timing are compared against them.
module tb_aidc_lite_decomp_bpc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, sop_i, eop_i, raw_i;
    logic [63:0] data_i;
    logic        busy_o, valid_o, sop_o, eop_o, done_o, error_o;
    logic [63:0] data_o;

    always #5 clk = ~clk;

    aidc_lite_decomp_bpc dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .sop_i   (sop_i),
        .eop_i   (eop_i),
        .raw_i   (raw_i),
        .data_i  (data_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .sop_o   (sop_o),
        .eop_o   (eop_o),
        .data_o  (data_o),
        .done_o  (done_o),
        .error_o (error_o)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] wds [32];
    bit          bits [$];
    logic [63:0] tx_beats [17];
    int          tx_n;
    bit          tx_raw;

    logic [63:0] obs_data [16];
    int          nv, sop_n, eop_n, done_n, err_n, busy_fall;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic put_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bits.push_back(v[i]);
    endtask

    task automatic pack_bits();
        tx_n = (bits.size() + 63) / 64;
        for (int b = 0; b < 17; b++) tx_beats[b] = '0;
        for (int i = 0; i < bits.size(); i++) tx_beats[i / 64][63 - (i % 64)] = bits[i];
    endtask

    // Reference compressor: planes of the word deltas, XORed with the plane above, coded greedily.
    task automatic encode_block();
        logic [32:0] d [32];
        logic [30:0] dbp [34];
        logic [30:0] dbx [33];
        int k, r, lsb;
        bits.delete();
        put_bits(wds[0], 32);
        d[0] = '0;
        for (int i = 1; i < 32; i++) d[i] = {1'b0, wds[i]} - {1'b0, wds[i-1]};
        for (int p = 0; p < 33; p++)
            for (int j = 0; j < 31; j++) dbp[p][j] = d[j+1][p];
        dbp[33] = '0;
        for (int p = 0; p < 33; p++) dbx[p] = dbp[p] ^ dbp[p+1];
        k = 32;
        while (k >= 0) begin
            if (dbx[k] == '0) begin
                r = 0;
                while (r <= k && dbx[k-r] == '0) r++;
                if (r == 1) put_bits(32'b01, 2);
                else        put_bits({24'd0, 3'b001, 5'(r - 2)}, 8);
                k -= r;
            end else begin
                lsb = 0;
                while (dbx[k][lsb] == 1'b0) lsb++;
                if (dbx[k] == '1)                   put_bits(32'b00000, 5);
                else if (dbp[k] == '0)              put_bits(32'b00001, 5);
                else if ($countones(dbx[k]) == 1)   put_bits({22'd0, 5'b00011, 5'(lsb)}, 10);
                else if ($countones(dbx[k]) == 2 && (dbx[k] >> lsb) == 31'd3)
                                                    put_bits({22'd0, 5'b00010, 5'(lsb)}, 10);
                else                                put_bits({1'b1, dbx[k]}, 32);
                k--;
            end
        end
        if (bits.size() > 1024) begin
            tx_raw = 1'b1;
            tx_n   = 16;
            for (int b = 0; b < 16; b++) tx_beats[b] = {wds[2*b+1], wds[2*b]};
        end else begin
            tx_raw = 1'b0;
            pack_bits();
        end
    endtask

    task automatic make_words(input int kind);
        logic [31:0] step;
        wds[0] = $urandom;
        step   = $urandom_range(1, 1000);
        for (int i = 1; i < 32; i++) begin
            case (kind)
                0: wds[i] = wds[0];
                1: wds[i] = wds[i-1] + step;
                2: wds[i] = wds[i-1] + $urandom_range(0, 255);
                3: wds[i] = wds[i-1] + $urandom_range(0, 32) - 32'd16;
                4: wds[i] = $urandom;
                default: wds[i] = wds[i-1] ^ (32'd1 << $urandom_range(0, 31));
            endcase
        end
    endtask

    task automatic send(input int nb, input bit raw, input bit with_eop);
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            valid_i = 1'b1;
            sop_i   = (b == 0);
            eop_i   = with_eop && (b == nb - 1);
            raw_i   = raw;
            data_i  = tx_beats[b];
        end
    endtask

    // Sample n counts edges after the one that accepted the last input beat.
    task automatic observe(input int inject_n);
        nv = 0; sop_n = -1; eop_n = -1; done_n = -1; err_n = -1; busy_fall = -1;
        for (int b = 0; b < 16; b++) obs_data[b] = '0;
        for (int n = 0; n <= 90; n++) begin
            @(negedge clk);
            if (valid_o) begin
                if (nv < 16) obs_data[nv] = data_o;
                nv++;
            end
            if (sop_o   && sop_n  < 0) sop_n  = n;
            if (eop_o   && eop_n  < 0) eop_n  = n;
            if (done_o  && done_n < 0) done_n = n;
            if (error_o && err_n  < 0) err_n  = n;
            if (!busy_o && done_n >= 0 && busy_fall < 0) busy_fall = n;
            if (n == inject_n) begin
                valid_i = 1'b1; sop_i = 1'b1; eop_i = 1'b1;
                raw_i   = 1'($urandom_range(0, 1));
                data_i  = {$urandom, $urandom};
            end else begin
                valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; raw_i = 1'b0; data_i = '0;
            end
            if (busy_fall >= 0) break;
        end
    endtask

    task automatic check_good(input string tag);
        int lat;
        lat = tx_raw ? 0 : 34;
        check({tag, ":nbeats"}, 64'(nv), 64'(16));
        check({tag, ":sop_cyc"}, 64'(sop_n), 64'(lat + 1));
        check({tag, ":eop_cyc"}, 64'(eop_n), 64'(lat + 16));
        check({tag, ":done_cyc"}, 64'(done_n), 64'(lat + 16));
        check({tag, ":no_err"}, 64'(err_n), 64'(-1));
        check({tag, ":busy_fall"}, 64'(busy_fall), 64'(lat + 17));
        for (int b = 0; b < 16; b++)
            check($sformatf("%s:beat%0d", tag, b), obs_data[b], {wds[2*b+1], wds[2*b]});
    endtask

    task automatic check_err(input string tag, input int exp_n);
        if (exp_n < 0) check({tag, ":err_seen"}, 64'(err_n >= 0), 64'(1));
        else           check({tag, ":err_cyc"}, 64'(err_n), 64'(exp_n));
        check({tag, ":done_with_err"}, 64'(done_n), 64'(err_n));
        check({tag, ":no_beats"}, 64'(nv), 64'(0));
        check({tag, ":busy_fall"}, 64'(busy_fall), 64'(err_n + 1));
    endtask

    task automatic run_words(input string tag, input int inject_n);
        encode_block();
        send(tx_n, tx_raw, 1'b1);
        observe(inject_n);
        check_good(tag);
    endtask

    initial begin
        int hits;
        rst_n = 1'b0; valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; raw_i = 1'b0; data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset:outs", {57'd0, busy_o, valid_o, sop_o, eop_o, done_o, error_o, ^data_o === 1'bx}, '0);
        check("reset:data", data_o, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) wds[i] = '0;
        run_words("zero", -1);
        check("zero:one_beat_stream", 64'(tx_n), 64'(1));
        for (int i = 0; i < 32; i++) wds[i] = 32'hDEADBEEF;
        run_words("const", -1);
        for (int i = 0; i < 32; i++) wds[i] = 32'(i);
        run_words("incr", -1);
        check("incr:stream_bits", 64'(bits.size()), 64'(45));

        for (int i = 0; i < 32; i++) wds[i] = $urandom;
        encode_block();
        tx_raw = 1'b1; tx_n = 16;
        for (int b = 0; b < 16; b++) tx_beats[b] = {wds[2*b+1], wds[2*b]};
        send(16, 1'b1, 1'b1);
        observe(5);
        check_good("raw_drop");

        make_words(2);
        run_words("emit_drop", 40);

        bits.delete(); put_bits($urandom, 32); put_bits(32'b01, 2); put_bits(32'b00111111, 8);
        pack_bits(); send(tx_n, 1'b0, 1'b1); observe(-1);
        check_err("run_below0", 3);

        bits.delete(); put_bits($urandom, 32); put_bits(32'b0001111111, 10);
        pack_bits(); send(tx_n, 1'b0, 1'b1); observe(-1);
        check_err("one_j31", 2);

        bits.delete(); put_bits($urandom, 32); put_bits(32'b0001011110, 10);
        pack_bits(); send(tx_n, 1'b0, 1'b1); observe(-1);
        check_err("two_j30", 2);

        make_words(2);
        encode_block();
        check("trunc:multibeat", 64'(tx_n >= 2), 64'(1));
        send(tx_n - 1, 1'b0, 1'b1); observe(-1);
        check_err("trunc", -1);

        for (int b = 0; b < 17; b++) tx_beats[b] = {$urandom, $urandom};
        send(17, 1'b0, 1'b0); observe(-1);
        check_err("overflow", 0);

        make_words(3);
        encode_block();
        send(tx_n, tx_raw, 1'b1);
        hits = 0;
        for (int n = 0; n <= 20; n++) begin
            @(negedge clk);
            valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; raw_i = 1'b0; data_i = '0;
        end
        rst_n = 1'b0;
        #1;
        check("midreset:outs", {58'd0, busy_o, valid_o, sop_o, eop_o, done_o, error_o}, '0);
        check("midreset:data", data_o, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (valid_o || done_o || busy_o || error_o) hits++;
        end
        check("midreset:quiet", 64'(hits), 64'(0));

        for (int t = 0; t < 24; t++) begin
            make_words(t % 6);
            run_words($sformatf("rand%0d_k%0d", t, t % 6), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
